reg_alu_sequencer: RTL

//  Command-driven controller for the keypad/register-bank/ALU datapath. Accepts one

---
 rtl/reg_alu_sequencer_if.sv | 66 ++++++
 rtl/reg_alu_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/reg_alu_sequencer_if.sv
// Purpose: bundles the command handshake, keypad strobe, register-bank and ALU
//          connections of the reg/ALU sequencer into one interface.
// Ports (signals):
//   cmd_valid/cmd_ready/cmd_op/cmd_a/cmd_b/cmd_d : command handshake and fields
//   key_valid/key_code                           : keypad-encoder strobe and code
//   rf_addr_a/rf_addr_b/rf_addr_wr/rf_wdata/rf_we: register-bank control
//   rf_doa/rf_dob                                : register-bank read data
//   alu_sel/alu_out/alu_carry/alu_zero           : ALU select and results
//   result/carry_flag/zero_flag                  : captured status
//   done/err/key_overrun                         : completion, error, overrun
// Modports: slave = the sequencer, master = the surrounding datapath/driver.
interface reg_alu_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2,
    parameter int KEY_W  = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_a;
    logic [ADDR_W-1:0] cmd_b;
    logic [ADDR_W-1:0] cmd_d;
    logic              key_valid;
    logic [KEY_W-1:0]  key_code;
    logic [ADDR_W-1:0] rf_addr_a;
    logic [ADDR_W-1:0] rf_addr_b;
    logic [ADDR_W-1:0] rf_addr_wr;
    logic [DATA_W-1:0] rf_wdata;
    logic              rf_we;
    logic [DATA_W-1:0] rf_doa;
    logic [DATA_W-1:0] rf_dob;
    logic [1:0]        alu_sel;
    logic [DATA_W-1:0] alu_out;
    logic              alu_carry;
    logic              alu_zero;
    logic [DATA_W-1:0] result;
    logic              carry_flag;
    logic              zero_flag;
    logic              done;
    logic              err;
    logic              key_overrun;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_d,
        input  key_valid, key_code,
        input  rf_doa, rf_dob,
        input  alu_out, alu_carry, alu_zero,
        output cmd_ready,
        output rf_addr_a, rf_addr_b, rf_addr_wr, rf_wdata, rf_we,
        output alu_sel,
        output result, carry_flag, zero_flag,
        output done, err, key_overrun
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_d,
        output key_valid, key_code,
        output rf_doa, rf_dob,
        output alu_out, alu_carry, alu_zero,
        input  cmd_ready,
        input  rf_addr_a, rf_addr_b, rf_addr_wr, rf_wdata, rf_we,
        input  alu_sel,
        input  result, carry_flag, zero_flag,
        input  done, err, key_overrun
    );
endinterface

// File: rtl/reg_alu_sequencer.sv
// Purpose: command-driven controller for the keypad / register-bank / ALU
//          datapath. Accepts one command at a time (valid/ready), sequences
//          bank reads, the ALU operation and bank write-back, and loads
//          keypad codes into the bank.
// Ports:
//   clk   : system clock, all state on the rising edge
//   reset : asynchronous, active-high reset
//   bus   : reg_alu_sequencer_if.slave (command, key, bank, ALU and status)
module reg_alu_sequencer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2,
    parameter int KEY_W  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    reg_alu_sequencer_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_READ     = 2'd1,
        S_WAIT_KEY = 2'd2,
        S_WRITE    = 2'd3
    } state_t;

    localparam logic [2:0] OP_LOAD_KEY = 3'd4;
    localparam logic [2:0] OP_CLEAR    = 3'd5;

    state_t            state_q,       state_d;
    logic [2:0]        op_q,          op_d;
    logic [ADDR_W-1:0] a_q,           a_d;
    logic [ADDR_W-1:0] b_q,           b_d;
    logic [ADDR_W-1:0] d_q,           d_d;
    logic              rsv_q,         rsv_d;
    logic [DATA_W-1:0] wdata_q,       wdata_d;
    logic [DATA_W-1:0] result_q,      result_d;
    logic              carry_q,       carry_d;
    logic              zero_q,        zero_d;
    logic              key_pending_q, key_pending_d;
    logic [KEY_W-1:0]  key_buf_q,     key_buf_d;
    logic              key_overrun_q, key_overrun_d;
    logic              consume_s;

    // Next-state, command latch, datapath capture and key buffering.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        a_d           = a_q;
        b_d           = b_q;
        d_d           = d_q;
        rsv_d         = rsv_q;
        wdata_d       = wdata_q;
        result_d      = result_q;
        carry_d       = carry_q;
        zero_d        = zero_q;
        key_pending_d = key_pending_q;
        key_buf_d     = key_buf_q;
        key_overrun_d = key_overrun_q;
        consume_s     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    op_d  = bus.cmd_op;
                    a_d   = bus.cmd_a;
                    b_d   = bus.cmd_b;
                    d_d   = bus.cmd_d;
                    rsv_d = 1'b0;
                    case (bus.cmd_op)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            state_d = S_READ;
                        end
                        OP_LOAD_KEY: begin
                            if (key_pending_q) begin
                                wdata_d   = DATA_W'(key_buf_q);
                                result_d  = DATA_W'(key_buf_q);
                                consume_s = 1'b1;
                                state_d   = S_WRITE;
                            end else begin
                                state_d = S_WAIT_KEY;
                            end
                        end
                        OP_CLEAR: begin
                            wdata_d  = {DATA_W{1'b0}};
                            result_d = {DATA_W{1'b0}};
                            state_d  = S_WRITE;
                        end
                        default: begin
                            // Reserved opcode: report via done/err, no bank write.
                            rsv_d   = 1'b1;
                            state_d = S_WRITE;
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                // Bank read data has fed the ALU for this whole cycle.
                wdata_d  = bus.alu_out;
                result_d = bus.alu_out;
                carry_d  = bus.alu_carry;
                zero_d   = bus.alu_zero;
                state_d  = S_WRITE;
            end
            S_WAIT_KEY: begin
                if (bus.key_valid) begin
                    wdata_d  = DATA_W'(bus.key_code);
                    result_d = DATA_W'(bus.key_code);
                    state_d  = S_WRITE;
                end else if (key_pending_q) begin
                    // Only reachable when a key arrived on the accepting edge.
                    wdata_d   = DATA_W'(key_buf_q);
                    result_d  = DATA_W'(key_buf_q);
                    consume_s = 1'b1;
                    state_d   = S_WRITE;
                end else begin
                    state_d = S_WAIT_KEY;
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Key capture; a key arriving on the consume edge becomes the new pending key.
        if (bus.key_valid && (state_q != S_WAIT_KEY)) begin
            key_pending_d = 1'b1;
            key_buf_d     = bus.key_code;
            if (key_pending_q && !consume_s) begin
                key_overrun_d = 1'b1;
            end else begin
                key_overrun_d = key_overrun_q;
            end
        end else if (consume_s) begin
            key_pending_d = 1'b0;
        end else begin
            key_pending_d = key_pending_q;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            op_q          <= 3'd0;
            a_q           <= {ADDR_W{1'b0}};
            b_q           <= {ADDR_W{1'b0}};
            d_q           <= {ADDR_W{1'b0}};
            rsv_q         <= 1'b0;
            wdata_q       <= {DATA_W{1'b0}};
            result_q      <= {DATA_W{1'b0}};
            carry_q       <= 1'b0;
            zero_q        <= 1'b0;
            key_pending_q <= 1'b0;
            key_buf_q     <= {KEY_W{1'b0}};
            key_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            a_q           <= a_d;
            b_q           <= b_d;
            d_q           <= d_d;
            rsv_q         <= rsv_d;
            wdata_q       <= wdata_d;
            result_q      <= result_d;
            carry_q       <= carry_d;
            zero_q        <= zero_d;
            key_pending_q <= key_pending_d;
            key_buf_q     <= key_buf_d;
            key_overrun_q <= key_overrun_d;
        end
    end

    // Strobes decode straight from the state register so reset drops them at once.
    assign bus.cmd_ready   = (state_q == S_IDLE);
    assign bus.rf_we       = (state_q == S_WRITE) && !rsv_q;
    assign bus.done        = (state_q == S_WRITE);
    assign bus.err         = (state_q == S_WRITE) && rsv_q;
    assign bus.rf_addr_a   = a_q;
    assign bus.rf_addr_b   = b_q;
    assign bus.rf_addr_wr  = d_q;
    assign bus.rf_wdata    = wdata_q;
    assign bus.alu_sel     = op_q[1:0];
    assign bus.result      = result_q;
    assign bus.carry_flag  = carry_q;
    assign bus.zero_flag   = zero_q;
    assign bus.key_overrun = key_overrun_q;

endmodule
